// File: rtl/cbrt_seq_ctrl_pkg.sv
// Shared constants for the cube-root sequencer:
// state encoding and derived-width helpers.
package cbrt_seq_ctrl_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FACTOR = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    function automatic int root_bits(input int width);
        return width / 3;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbrt_seq_ctrl_if.sv
// Requester-side bundle of the cube-root sequencer:
// start/done handshake, operand and result.
interface cbrt_seq_ctrl_if
    import cbrt_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 12
);
    localparam int RW = root_bits(WIDTH);

    logic             start;
    logic [WIDTH-1:0] radicand;
    logic             ready;
    logic             busy;
    logic             done;
    logic [RW-1:0]    root;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, radicand,
        input  ready, busy, done,
        input  root, remainder
    );

    modport slave (
        input  start, radicand,
        output ready, busy, done,
        output root, remainder
    );

endinterface

// File: rtl/cbrt_seq_ctrl_factor.sv
// Trial factor (3*yp*yp + 3*yp + 1) << 3k,
// evaluated at full width so nothing is lost.
module cbrt_factor #(
    parameter int WIDTH = 12,
    parameter int RW    = 4,
    parameter int KW    = 2
) (
    input  logic [RW-1:0]    yp,
    input  logic [KW-1:0]    k,
    output logic [WIDTH+2:0] fac
);
    localparam int FW = WIDTH + 3;
    localparam logic [FW-1:0] ONE   = 1;
    localparam logic [FW-1:0] THREE = 3;

    logic [FW-1:0] y_w;
    logic [FW-1:0] base;
    logic [KW+1:0] sh;

    assign y_w  = FW'(yp);
    assign base = THREE * y_w * y_w
                + THREE * y_w + ONE;
    assign sh   = {2'b00, k} + {1'b0, k, 1'b0};
    assign fac  = base << sh;

endmodule

// File: rtl/cbrt_seq_ctrl.sv
// Restoring integer cube root, one root bit
// per FACTOR/UPDATE pair, MSB first.
module cbrt_seq_ctrl
    import cbrt_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst,
    cbrt_seq_ctrl_if.slave bus
);
    localparam int RW   = root_bits(WIDTH);
    localparam int ITER = root_bits(WIDTH);
    localparam int KW   = cnt_bits(ITER);
    localparam int FW   = WIDTH + 3;

    if (WIDTH % 3 != 0) begin : g_width_chk
        $error("cbrt_seq_ctrl: WIDTH must be a multiple of 3");
    end

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [RW-1:0]    y;
    logic [RW-1:0]    y_nxt;
    logic [RW-1:0]    yp;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nxt;
    logic [FW-1:0]    fac;
    logic [FW-1:0]    fac_c;
    logic             take;
    logic [RW-1:0]    root;
    logic [WIDTH-1:0] remainder;

    // y never reaches its top bit before the last shift
    assign yp = y << 1;

    cbrt_factor #(
        .WIDTH (WIDTH),
        .RW    (RW),
        .KW    (KW)
    ) u_factor (
        .yp  (yp),
        .k   (k),
        .fac (fac_c)
    );

    assign take = {3'b000, rem} >= fac;

    always_comb begin
        y_nxt   = (y << 1) | RW'(take);
        rem_nxt = rem;
        if (take)
            rem_nxt = rem - fac[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            y         <= '0;
            rem       <= '0;
            fac       <= '0;
            root      <= '0;
            remainder <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (bus.start) begin
                        rem   <= bus.radicand;
                        y     <= '0;
                        k     <= KW'(ITER - 1);
                        state <= FACTOR;
                    end
                end
                (state == FACTOR): begin
                    fac   <= fac_c;
                    state <= UPDATE;
                end
                (state == UPDATE): begin
                    y   <= y_nxt;
                    rem <= rem_nxt;
                    if (k == '0) begin
                        root      <= y_nxt;
                        remainder <= rem_nxt;
                        state     <= DONE;
                    end else begin
                        k     <= k - 1'b1;
                        state <= FACTOR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.busy      = (state == FACTOR)
                         | (state == UPDATE);
    assign bus.done      = (state == DONE);
    assign bus.root      = root;
    assign bus.remainder = remainder;

endmodule

// File: tb/tb_cbrt_seq_ctrl.sv
// Directed and randomized checks of the cube-root
// sequencer against a plain arithmetic model.
module tb_cbrt_seq_ctrl;
    localparam int WIDTH = 12;
    localparam int ITER  = WIDTH / 3;
    localparam int LAT   = 2 * ITER;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    cbrt_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    cbrt_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_root(input int x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x)
            r++;
        return r;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, want %0d",
                    tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic do_op(input int x, input string tag);
        int n;
        int r;
        n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".ready_in"}, bus.ready, 1);
        bus.start    = 1'b1;
        bus.radicand = x[WIDTH-1:0];
        tick();
        bus.start = 1'b0;
        check({tag, ".busy"}, bus.busy, 1);
        wait_done(n);
        check({tag, ".latency"}, n, LAT);
        r = ref_root(x);
        check({tag, ".root"}, bus.root, r);
        check({tag, ".rem"}, bus.remainder, x - r * r * r);
        tick();
        check({tag, ".done_off"}, bus.done, 0);
        check({tag, ".ready_out"}, bus.ready, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dcnt;
        bus.start    = 1'b0;
        bus.radicand = '0;
        rst          = 1'b0;
        repeat (3) tick();
        check("rst.ready", bus.ready, 1);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.root", bus.root, 0);
        check("rst.rem", bus.remainder, 0);
        rst = 1'b1;
        tick();
        check("post_rst.ready", bus.ready, 1);

        do_op(27, "r27");
        do_op(4095, "r4095");
        do_op(0, "r0");

        // a second start mid-flight must be ignored
        bus.start    = 1'b1;
        bus.radicand = 12'd999;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start    = 1'b1;
        bus.radicand = 12'd8;
        tick();
        bus.start = 1'b0;
        check("ign.busy", bus.busy, 1);
        check("ign.ready", bus.ready, 0);
        check("ign.root_hold", bus.root, 0);
        check("ign.rem_hold", bus.remainder, 0);
        wait_done(n);
        check("ign.latency", n, LAT - 3);
        check("ign.root", bus.root, 9);
        check("ign.rem", bus.remainder, 270);
        tick();

        // start held high: back-to-back operations
        bus.start    = 1'b1;
        bus.radicand = 12'd999;
        tick();
        bus.radicand = 12'd1000;
        wait_done(n);
        check("b2b.lat1", n, LAT);
        check("b2b.root1", bus.root, 9);
        check("b2b.rem1", bus.remainder, 270);
        tick();
        check("b2b.ready", bus.ready, 1);
        tick();
        tick();
        check("b2b.busy2", bus.busy, 1);
        check("b2b.root_hold", bus.root, 9);
        check("b2b.rem_hold", bus.remainder, 270);
        wait_done(n);
        check("b2b.gap", n + 3, LAT + 2);
        bus.start = 1'b0;
        check("b2b.root2", bus.root, 10);
        check("b2b.rem2", bus.remainder, 0);
        tick();

        // asynchronous reset in the middle of an operation
        bus.start    = 1'b1;
        bus.radicand = 12'd500;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("arst.ready", bus.ready, 1);
        check("arst.busy", bus.busy, 0);
        check("arst.done", bus.done, 0);
        check("arst.root", bus.root, 0);
        check("arst.rem", bus.remainder, 0);
        repeat (2) tick();
        rst  = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1)
                dcnt++;
        end
        check("arst.no_done", dcnt, 0);
        do_op(64, "r64");

        for (int i = 0; i < 40; i++)
            do_op(int'($urandom_range(0, 4095)), "rand");

        for (int x = 0; x < 4096; x++)
            do_op(x, "sweep");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
